regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (WE3/A3/WD3) between two writers:
//  the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
//  - Holds one pending MDU result in a buffer.
//  - Keeps a per-register pending-write scoreboard that hazard logic reads for stalls.
//  - Asserts a writeback stall when the MDU has lost arbitration for too long.

---
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between the writeback stage
// and the multiply/divide unit. One MDU result can be parked in a buffer; a
// per-register scoreboard tracks MDU destinations that are still in flight,
// and a starvation counter forces the parked result through once writeback
// has won the port for too long.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_we,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_stall,
   input  logic                  mdu_issue,
   input  logic [ADDR_WIDTH-1:0] mdu_issue_addr,
   input  logic                  mdu_valid,
   output logic                  mdu_ready,
   input  logic [ADDR_WIDTH-1:0] mdu_addr,
   input  logic [DATA_WIDTH-1:0] mdu_data,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   output logic                  rs_busy,
   output logic                  rt_busy,
   output logic                  WE3,
   output logic [ADDR_WIDTH-1:0] A3,
   output logic [DATA_WIDTH-1:0] WD3
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic                  buf_valid_r;
   logic [ADDR_WIDTH-1:0] buf_addr_r;
   logic [DATA_WIDTH-1:0] buf_data_r;
   logic [3:0]            starve_cnt_r;
   logic [DEPTH-1:0]      sb_r;

   logic                  force_s;
   logic                  mdu_grant_s;
   logic                  wb_grant_s;
   logic                  accept_s;
   logic [DEPTH-1:0]      sb_set_s;
   logic [DEPTH-1:0]      sb_clr_s;
   logic [DEPTH-1:0]      sb_next_s;

   assign accept_s  = mdu_valid & ~buf_valid_r;
   assign mdu_ready = ~buf_valid_r;
   assign rs_busy   = sb_r[rs_addr];
   assign rt_busy   = sb_r[rt_addr];

   // Write-port arbitration: a starved buffer beats writeback, otherwise writeback first.
   always_comb begin
      force_s     = buf_valid_r & (starve_cnt_r >= 4'(STARVE_LIMIT));
      mdu_grant_s = 1'b0;
      wb_grant_s  = 1'b0;
      wb_stall    = 1'b0;
      A3          = '0;
      WD3         = '0;
      if (!rst) begin
         // Port stays quiet while reset is held, whatever writeback presents.
         force_s = 1'b0;
      end else if (force_s) begin
         mdu_grant_s = 1'b1;
         wb_stall    = 1'b1;
         A3          = buf_addr_r;
         WD3         = buf_data_r;
      end else if (wb_we) begin
         wb_grant_s  = 1'b1;
         A3          = wb_addr;
         WD3         = wb_data;
      end else if (buf_valid_r) begin
         mdu_grant_s = 1'b1;
         A3          = buf_addr_r;
         WD3         = buf_data_r;
      end else begin
         mdu_grant_s = 1'b0;
      end
      // Register 0 is hardwired; a grant to it completes without a write.
      WE3 = (mdu_grant_s | wb_grant_s) & (A3 != '0);
   end

   // Scoreboard next state: issue sets, MDU grant clears, set wins, entry 0 pinned low.
   always_comb begin
      sb_set_s                 = '0;
      sb_clr_s                 = '0;
      sb_set_s[mdu_issue_addr] = mdu_issue & (mdu_issue_addr != '0);
      sb_clr_s[buf_addr_r]     = mdu_grant_s;
      sb_next_s                = (sb_r & ~sb_clr_s) | sb_set_s;
      sb_next_s[0]             = 1'b0;
   end

   // Result buffer: drain on MDU grant, load on accept (never both in one cycle).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid_r <= 1'b0;
         buf_addr_r  <= '0;
         buf_data_r  <= '0;
      end else if (mdu_grant_s) begin
         buf_valid_r <= 1'b0;
      end else if (accept_s) begin
         buf_valid_r <= 1'b1;
         buf_addr_r  <= mdu_addr;
         buf_data_r  <= mdu_data;
      end
   end

   // Starvation counter: counts writeback wins over a waiting result, saturating at 15.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_r <= 4'd0;
      end else if (!buf_valid_r || mdu_grant_s) begin
         starve_cnt_r <= 4'd0;
      end else if (wb_grant_s && (starve_cnt_r != 4'd15)) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_r <= '0;
      end else begin
         sb_r <= sb_next_s;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a sequential vector table covering
// writeback, idle-port MDU writes, register-0 results and set/clear collisions,
// plus hand-written starvation and mid-operation reset sequences.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        mdu_issue;
   logic [4:0]  mdu_issue_addr;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic [4:0]  rs_addr, rt_addr;
   logic        rs_busy, rt_busy;
   logic        WE3;
   logic [4:0]  A3;
   logic [31:0] WD3;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
      .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_addr(mdu_addr), .mdu_data(mdu_data),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .WE3(WE3), .A3(A3), .WD3(WD3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        iss;
      logic [4:0]  iss_addr;
      logic        mv;
      logic [4:0]  maddr;
      logic [31:0] mdata;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        e_we3;
      logic [4:0]  e_a3;
      logic [31:0] e_wd3;
      logic        e_stall;
      logic        e_ready;
      logic        e_rsb;
      logic        e_rtb;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      mdu_issue = 1'b0; mdu_issue_addr = 5'd0;
      mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
      rs_addr = 5'd0; rt_addr = 5'd0;
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          wb_we wb_a   wb_d            iss   iss_a mv    m_a   m_d           rs    rt    we3   a3    wd3           stall ready rsb   rtb
      vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd5, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd5, 5'd9, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd0, 32'h0,    5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd9, 32'h1234, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd9, 5'd9, 1'b1, 5'd9, 32'h1234,     1'b0, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 32'h55,   5'd0, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 32'h0,    5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 32'h77,   5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 32'h0,    5'd7, 5'd7, 1'b1, 5'd7, 32'h77,       1'b0, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    5'd7, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};

      // Reset state while reset is held, with writeback requesting.
      idle_inputs();
      rst = 1'b0;
      wb_we = 1'b1; wb_addr = 5'd4; rs_addr = 5'd5;
      #2;
      chk("reset_we3",   {31'd0, WE3},       32'd0);
      chk("reset_stall", {31'd0, wb_stall},  32'd0);
      chk("reset_ready", {31'd0, mdu_ready}, 32'd1);
      chk("reset_rsbusy",{31'd0, rs_busy},   32'd0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      idle_inputs();

      // Table: one vector per cycle, state carries from row to row.
      for (int i = 0; i < 13; i++) begin
         wb_we = vecs[i].wb_we; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
         mdu_issue = vecs[i].iss; mdu_issue_addr = vecs[i].iss_addr;
         mdu_valid = vecs[i].mv; mdu_addr = vecs[i].maddr; mdu_data = vecs[i].mdata;
         rs_addr = vecs[i].rs; rt_addr = vecs[i].rt;
         #2;
         chk($sformatf("v%0d_we3", i),   {31'd0, WE3},       {31'd0, vecs[i].e_we3});
         if (vecs[i].e_we3) begin
            chk($sformatf("v%0d_a3", i),  {27'd0, A3},       {27'd0, vecs[i].e_a3});
            chk($sformatf("v%0d_wd3", i), WD3,               vecs[i].e_wd3);
         end
         chk($sformatf("v%0d_stall", i), {31'd0, wb_stall},  {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d_ready", i), {31'd0, mdu_ready}, {31'd0, vecs[i].e_ready});
         chk($sformatf("v%0d_rsbusy", i),{31'd0, rs_busy},   {31'd0, vecs[i].e_rsb});
         chk($sformatf("v%0d_rtbusy", i),{31'd0, rt_busy},   {31'd0, vecs[i].e_rtb});
         next_cycle();
      end
      idle_inputs();
      next_cycle();

      // Starvation: result for reg 3 parked while writeback requests every cycle.
      mdu_issue = 1'b1; mdu_issue_addr = 5'd3;
      mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'hABCD;
      next_cycle();
      idle_inputs();
      rs_addr = 5'd3;
      for (int c = 0; c < 4; c++) begin
         wb_we = 1'b1; wb_addr = 5'(10 + c); wb_data = 32'(100 + c);
         #2;
         chk($sformatf("starve%0d_we3", c),   {31'd0, WE3},       32'd1);
         chk($sformatf("starve%0d_a3", c),    {27'd0, A3},        32'(10 + c));
         chk($sformatf("starve%0d_stall", c), {31'd0, wb_stall},  32'd0);
         chk($sformatf("starve%0d_ready", c), {31'd0, mdu_ready}, 32'd0);
         chk($sformatf("starve%0d_busy", c),  {31'd0, rs_busy},   32'd1);
         next_cycle();
      end
      wb_addr = 5'd14; wb_data = 32'd104;
      #2;
      chk("force_stall", {31'd0, wb_stall}, 32'd1);
      chk("force_we3",   {31'd0, WE3},      32'd1);
      chk("force_a3",    {27'd0, A3},       32'd3);
      chk("force_wd3",   WD3,               32'hABCD);
      next_cycle();
      #2;
      chk("resume_stall", {31'd0, wb_stall},  32'd0);
      chk("resume_a3",    {27'd0, A3},        32'd14);
      chk("resume_wd3",   WD3,                32'd104);
      chk("resume_ready", {31'd0, mdu_ready}, 32'd1);
      chk("resume_busy",  {31'd0, rs_busy},   32'd0);
      next_cycle();
      idle_inputs();

      // Mid-operation reset: full buffer and sb[5]=1 are dropped asynchronously.
      mdu_issue = 1'b1; mdu_issue_addr = 5'd5;
      mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h5A5A;
      next_cycle();
      idle_inputs();
      rs_addr = 5'd5;
      #1;
      chk("prerst_ready", {31'd0, mdu_ready}, 32'd0);
      chk("prerst_busy",  {31'd0, rs_busy},   32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_we3",   {31'd0, WE3},       32'd0);
      chk("midrst_ready", {31'd0, mdu_ready}, 32'd1);
      chk("midrst_busy",  {31'd0, rs_busy},   32'd0);
      next_cycle();
      rst = 1'b1;
      #2;
      chk("postrst_we3",  {31'd0, WE3},       32'd0);
      chk("postrst_busy", {31'd0, rs_busy},   32'd0);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
